// File: rtl/traceback_reader_if.sv
// Operation stream from traceback_reader to a downstream consumer.
// The reader drives the master side; the consumer supplies ready.
interface traceback_reader_if #(
    parameter int unsigned CWIDTH = 2
);
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_op;
    logic [CWIDTH-1:0] out_c1;
    logic [CWIDTH-1:0] out_c2;
    logic              out_last;

    modport master (
        output out_valid, out_op, out_c1, out_c2, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_op, out_c1, out_c2, out_last,
        output out_ready
    );
endinterface

// File: rtl/traceback_reader.sv
// Replays the traceback coordinate list (stored end-first) as a forward stream of
// alignment operations, validating every step of the path and flagging corrupt traces.
module traceback_reader #(
    parameter int unsigned LENGTH      = 10,
    parameter int unsigned CWIDTH      = 2,
    parameter int unsigned CORD_LENGTH = 8,
    parameter int unsigned MEM_SIZE    = 9,
    parameter int unsigned BYTE_SIZE   = 2 * CORD_LENGTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic [MEM_SIZE-1:0]        i_count,
    input  logic [LENGTH*CWIDTH-1:0]   i_s1,
    input  logic [LENGTH*CWIDTH-1:0]   i_s2,
    output logic [MEM_SIZE-1:0]        o_raddr,
    input  logic [BYTE_SIZE-1:0]       i_rdata,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    traceback_reader_if.master         op_if
);
    localparam logic [CORD_LENGTH-1:0] LastCord = CORD_LENGTH'(LENGTH - 1);
    localparam logic [MEM_SIZE-1:0]    MaxCount = MEM_SIZE'(2 * LENGTH - 1);
    localparam logic [MEM_SIZE-1:0]    AddrOne  = MEM_SIZE'(1);
    localparam logic [CORD_LENGTH:0]   CordOne  = (CORD_LENGTH + 1)'(1);

    typedef enum logic [1:0] {StIdle, StRead, StCapture, StEmit} state_e;

    state_e r_state, w_state_next;

    logic [MEM_SIZE-1:0]    r_raddr, w_raddr_next;
    logic                   r_valid, w_valid_next;
    logic [1:0]             r_op, w_op_next;
    logic [CWIDTH-1:0]      r_c1, w_c1_next;
    logic [CWIDTH-1:0]      r_c2, w_c2_next;
    logic                   r_last, w_last_next;
    logic                   r_busy, w_busy_next;
    logic                   r_done, w_done_next;
    logic                   r_error, w_error_next;
    logic                   r_first, w_first_next;
    logic [CORD_LENGTH-1:0] r_px, w_px_next, r_py, w_py_next;
    logic [CORD_LENGTH-1:0] r_cx, w_cx_next, r_cy, w_cy_next;

    logic [CORD_LENGTH-1:0] w_x, w_y;
    logic                   w_dx0, w_dx1, w_dy0, w_dy1;
    logic                   w_diag, w_gap2, w_gap1, w_legal;
    logic [CWIDTH-1:0]      w_s1c, w_s2c;

    assign w_x = i_rdata[CORD_LENGTH-1:0];
    assign w_y = i_rdata[2*CORD_LENGTH-1:CORD_LENGTH];

    // Widened by one bit so px+1 can never wrap into a false match.
    assign w_dx0 = (w_x == r_px);
    assign w_dy0 = (w_y == r_py);
    assign w_dx1 = ({1'b0, w_x} == ({1'b0, r_px} + CordOne));
    assign w_dy1 = ({1'b0, w_y} == ({1'b0, r_py} + CordOne));

    // From the virtual (-1,-1) the only legal step is the diagonal onto (0,0).
    assign w_diag = r_first ? ((w_x == '0) && (w_y == '0)) : (w_dx1 && w_dy1);
    assign w_gap1 = !r_first && w_dx0 && w_dy1;
    assign w_gap2 = !r_first && w_dx1 && w_dy0;

    assign w_legal = (w_x <= LastCord) && (w_y <= LastCord)
                   && (w_diag || w_gap1 || w_gap2)
                   && ((r_raddr != '0) || ((w_x == LastCord) && (w_y == LastCord)));

    always_comb begin
        w_s1c = '0;
        w_s2c = '0;
        for (int i = 0; i < int'(LENGTH); i++) begin
            if (w_y == CORD_LENGTH'(i)) w_s1c = i_s1[i*CWIDTH +: CWIDTH];
            if (w_x == CORD_LENGTH'(i)) w_s2c = i_s2[i*CWIDTH +: CWIDTH];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_raddr_next = r_raddr;
        w_valid_next = r_valid;
        w_op_next    = r_op;
        w_c1_next    = r_c1;
        w_c2_next    = r_c2;
        w_last_next  = r_last;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_error_next = r_error;
        w_first_next = r_first;
        w_px_next    = r_px;
        w_py_next    = r_py;
        w_cx_next    = r_cx;
        w_cy_next    = r_cy;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if ((i_count == '0) || (i_count > MaxCount)) begin
                        w_error_next = 1'b1;
                    end else begin
                        w_error_next = 1'b0;
                        w_raddr_next = i_count - AddrOne;
                        w_busy_next  = 1'b1;
                        w_first_next = 1'b1;
                        w_state_next = StRead;
                    end
                end
            end
            StRead: w_state_next = StCapture;
            StCapture: begin
                if (!w_legal) begin
                    w_error_next = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = StIdle;
                end else begin
                    w_cx_next    = w_x;
                    w_cy_next    = w_y;
                    w_valid_next = 1'b1;
                    w_last_next  = (r_raddr == '0);
                    w_c1_next    = w_gap2 ? '0 : w_s1c;
                    w_c2_next    = w_gap1 ? '0 : w_s2c;
                    if (w_gap1)      w_op_next = 2'b10;
                    else if (w_gap2) w_op_next = 2'b11;
                    else             w_op_next = (w_s1c == w_s2c) ? 2'b00 : 2'b01;
                    w_state_next = StEmit;
                end
            end
            StEmit: begin
                if (op_if.out_ready) begin
                    w_valid_next = 1'b0;
                    if (r_last) begin
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                        w_state_next = StIdle;
                    end else begin
                        w_raddr_next = r_raddr - AddrOne;
                        w_px_next    = r_cx;
                        w_py_next    = r_cy;
                        w_first_next = 1'b0;
                        w_state_next = StRead;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr <= '0;
            r_valid <= 1'b0;
            r_op    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_first <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
        end else begin
            r_raddr <= w_raddr_next;
            r_valid <= w_valid_next;
            r_op    <= w_op_next;
            r_c1    <= w_c1_next;
            r_c2    <= w_c2_next;
            r_last  <= w_last_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_error <= w_error_next;
            r_first <= w_first_next;
            r_px    <= w_px_next;
            r_py    <= w_py_next;
            r_cx    <= w_cx_next;
            r_cy    <= w_cy_next;
        end
    end

    assign o_raddr         = r_raddr;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_error         = r_error;
    assign op_if.out_valid = r_valid;
    assign op_if.out_op    = r_op;
    assign op_if.out_c1    = r_c1;
    assign op_if.out_c2    = r_c2;
    assign op_if.out_last  = r_last;
endmodule
